multicycle_controller: RTL
==========================

# multicycle_controller

Control unit for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath strobe and mux select. It also drives the 3-bit `ctrl` code consumed by the ALU, so it is the producer end of the ALU control interface. It sits between the instruction register (opcode/funct) and the datapath: register file, memory port, PC and ALU.

## Interface
- No parameters. Encodings come from the shared header.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: instr[31:26] from the instruction register.
- `funct` in 6: instr[5:0] from the instruction register.
- `zero` in 1: ALU result equals 0.
- `alu_ctrl` out 3: ALU operation code.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = memory data.
- `ir_write`, `mem_write`, `reg_write`, `pc_en` out 1 each: write strobes.
- `illegal` out 1: unsupported opcode seen in DECODE.

## Operation
- The state register is the only storage. All outputs are decoded combinationally from the state register; `alu_ctrl` also depends on `funct`.
- `pc_en` = pc_write | (branch & `zero`). `pc_write` and `branch` are internal state decodes.
- ALU ctrl codes: AND 000, OR 001, ADD 010, SLL 011, ANDN 100, ORN 101, SUB 110, SLT 111.
- ALU decode from aluop:
  - aluop 00 -> ADD.
  - aluop 01 -> SUB.
  - aluop 10 -> decode `funct`: 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 101010 -> SLT. Any other funct -> ADD.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Per-state asserted signals; anything not listed is 0:
  - FETCH: ir_write, pc_write, alu_src_b = 01, aluop 00.
  - DECODE: alu_src_b = 11, aluop 00.
  - MEMADR: alu_src_a, alu_src_b = 10, aluop 00.
  - MEMREAD: iord.
  - MEMWB: mem_to_reg, reg_write.
  - MEMWRITE: iord, mem_write.
  - EXECUTE: alu_src_a, aluop 10.
  - ALUWB: reg_dst, reg_write.
  - BRANCH: alu_src_a, aluop 01, pc_src = 01, branch.
  - ADDIEXEC: alu_src_a, alu_src_b = 10, aluop 00.
  - ADDIWB: reg_write.
  - JUMP: pc_src = 10, pc_write.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR (lw, sw) / EXECUTE (R-type) / BRANCH (beq) / ADDIEXEC (addi) / JUMP (j) / FETCH (any other opcode, with `illegal` = 1 in that DECODE cycle).
  - MEMADR -> MEMREAD (lw) / MEMWRITE (sw).
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTE -> ALUWB -> FETCH.
  - ADDIEXEC -> ADDIWB -> FETCH.
  - BRANCH -> FETCH. JUMP -> FETCH.
- SLT emits 111 regardless of the current ALU result for that code; the controller does not special-case it.

## Timing
- While `rst` = 1:
  - The state loads FETCH on every edge.
  - All strobes are forced to 0: ir_write, mem_write, reg_write, pc_en, illegal.
  - All selects are forced to 0 and `alu_ctrl` to 010.
- The first cycle after `rst` falls is FETCH, with strobes active.
- Reset asserted mid-instruction aborts it at the next edge. No write strobe is asserted in the reset cycle.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `opcode`/`funct` need only be stable from DECODE onward; they are captured by ir_write at the end of FETCH.
- `zero` is sampled combinationally in BRANCH only.

## Structure
- Shared header constants.vh gains:
  - opcode and funct defines;
  - ALU ctrl defines;
  - aluop defines;
  - 4-bit state encodings for the 12 states.
- One natural sub-module: `alu_decoder` (aluop, funct -> alu_ctrl). It is purely combinational and instantiated once.
- The top holds the state register, next-state logic and the output decode.

## Test plan
- Reset, then opcode 100011 (lw): states cycle FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. reg_write = 1 with mem_to_reg = 1 in cycle 5 only.
- sw 101011: mem_write = 1 with iord = 1 in cycle 4. reg_write stays 0 throughout.
- R-type with funct 100010 -> alu_ctrl = 110 in EXECUTE. funct 101010 -> 111. funct 111111 -> 010. ALUWB has reg_dst = 1.
- beq: with `zero` = 1 in BRANCH, pc_en = 1 and pc_src = 01. With `zero` = 0, pc_en = 0. Next state is FETCH in both cases.
- Opcode 111111: `illegal` = 1 for exactly the DECODE cycle, then FETCH with no write strobes in between. j 000010 -> JUMP with pc_en = 1 and pc_src = 10.
- Assert `rst` during MEMREAD of a lw: MEMWB is never entered, reg_write never pulses, and FETCH follows the reset release.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct
// codes, ALU control codes, aluop classes and the controller state set.
package multicycle_controller_pkg;

  // Instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes driven to the ALU
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // Operation class handed from the state decode to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Controller states, 4-bit encoding
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: maps the aluop class and R-type funct to the 3-bit
// code consumed by the ALU. Purely combinational.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_ctrl
);

  // Select the ALU operation; unknown funct and unused aluop fall back to ADD
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: sequences each instruction through its
// states and decodes every datapath strobe and mux select from the state.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_en,
  output logic       illegal
);

  state_t state;
  state_t next_state;
  aluop_t aluop;
  logic   pc_write;
  logic   branch;

  // State register; reset returns to FETCH on any edge
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state selection from current state and opcode
  always_comb begin
    next_state = S_FETCH;
    unique case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEXEC;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ADDIEXEC: next_state = S_ADDIWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // Output decode; reset holds every strobe and select at 0 and aluop at ADD
  // regardless of the state being aborted
  always_comb begin
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    aluop      = ALUOP_ADD;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          unique case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
            default:                                       illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMREAD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_SUB;
          pc_src    = 2'b01;
          branch    = 1'b1;
        end
        S_ADDIEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en = pc_write | (branch & zero);

  alu_decoder u_alu_decoder (
    .aluop    (aluop),
    .funct    (funct),
    .alu_ctrl (alu_ctrl)
  );

endmodule
